// File: rtl/musica_pkg.sv
// Note codes, tone values, song entry layout, FSM states and the fixed melody ROM
// shared by the melody sequencer and its beat generator.
package musica_pkg;

    localparam logic [2:0] NOTA_OFF = 3'd0;
    localparam logic [2:0] NOTA_A   = 3'd1;
    localparam logic [2:0] NOTA_B   = 3'd2;
    localparam logic [2:0] NOTA_C   = 3'd3;
    localparam logic [2:0] NOTA_D   = 3'd4;
    localparam logic [2:0] NOTA_E   = 3'd5;
    localparam logic [2:0] NOTA_F   = 3'd6;
    localparam logic [2:0] NOTA_G   = 3'd7;

    localparam logic TOM_ALTO  = 1'b0;
    localparam logic TOM_BAIXO = 1'b1;

    // dur holds beats-1, so a note lasts dur+1 beats before its silent beat
    typedef struct packed {
        logic [2:0] nota;
        logic       tom;
        logic [2:0] dur;
    } entrada_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } estado_t;

    localparam entrada_t SONG_ROM [16] = '{
        '{NOTA_C,   TOM_ALTO,  3'd1},
        '{NOTA_D,   TOM_ALTO,  3'd0},
        '{NOTA_E,   TOM_ALTO,  3'd0},
        '{NOTA_G,   TOM_BAIXO, 3'd2},
        '{NOTA_F,   TOM_ALTO,  3'd1},
        '{NOTA_E,   TOM_ALTO,  3'd0},
        '{NOTA_D,   TOM_ALTO,  3'd0},
        '{NOTA_OFF, TOM_ALTO,  3'd1},
        '{NOTA_A,   TOM_BAIXO, 3'd0},
        '{NOTA_B,   TOM_BAIXO, 3'd0},
        '{NOTA_C,   TOM_ALTO,  3'd2},
        '{NOTA_G,   TOM_ALTO,  3'd1},
        '{NOTA_F,   TOM_BAIXO, 3'd0},
        '{NOTA_E,   TOM_ALTO,  3'd0},
        '{NOTA_D,   TOM_ALTO,  3'd1},
        '{NOTA_C,   TOM_ALTO,  3'd3}
    };

endpackage

// File: rtl/gerador_tick.sv
// Purpose: beat prescaler, counts 0..TICK_DIV-1 and flags the last count as the beat.
// Latency: beat is combinational from the count register; clr zeroes the count next edge.
// Backpressure: none; free-running whenever clr is low.
module gerador_tick #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic beat
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign beat = (cnt == CNT_MAX);

endmodule

// File: rtl/sequenciador_notas.sv
// Purpose: walks SONG_ROM driving note code {N1,N2,N3} and tone D, one silent beat after each note.
// Latency: start/stop sampled at an edge take effect on the outputs right after that edge.
// Backpressure: none; start while busy is ignored, stop always wins. SEQ_LOOP_EN selects looping playback.
module sequenciador_notas #(
    parameter int TICK_DIV = 12_500_000,
    parameter int SONG_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       N1,
    output logic       N2,
    output logic       N3,
    output logic       D,
    output logic       busy,
    output logic       done,
    output logic [3:0] idx
);

    import musica_pkg::*;

    localparam logic [3:0] IDX_ULTIMO = 4'(SONG_LEN - 1);

    estado_t    state, state_nxt;
    logic [2:0] beat_cnt, beat_cnt_nxt;
    logic [3:0] idx_nxt;
    logic [2:0] nota_nxt;
    logic       tom_nxt, busy_nxt, done_nxt;
    logic       beat;

    // Prescaler held at zero while idle so the first note gets full beats
    gerador_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .beat  (beat)
    );

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        beat_cnt_nxt = beat_cnt;
        done_nxt     = 1'b0;
        nota_nxt     = NOTA_OFF;
        tom_nxt      = TOM_ALTO;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_PLAY;
                    idx_nxt      = '0;
                    beat_cnt_nxt = '0;
                end
            end
            ST_PLAY: begin
                if (beat) begin
                    if (beat_cnt == SONG_ROM[idx].dur) begin
                        state_nxt    = ST_GAP;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                    end
                end
            end
            ST_GAP: begin
                if (beat) begin
                    if (idx == IDX_ULTIMO) begin
                        idx_nxt = '0;
`ifdef SEQ_LOOP_EN
                        state_nxt = ST_PLAY;
`else
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
`endif
                    end else begin
                        state_nxt = ST_PLAY;
                        idx_nxt   = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end
        endcase

        if (stop) begin
            state_nxt    = ST_IDLE;
            idx_nxt      = '0;
            beat_cnt_nxt = '0;
            done_nxt     = 1'b0;
        end

        // Outputs reflect the state being entered, so they register in step with it
        if (state_nxt == ST_PLAY) begin
            nota_nxt = SONG_ROM[idx_nxt].nota;
            tom_nxt  = SONG_ROM[idx_nxt].tom;
        end
        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            idx      <= '0;
            {N1, N2, N3} <= NOTA_OFF;
            D        <= TOM_ALTO;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            idx      <= idx_nxt;
            {N1, N2, N3} <= nota_nxt;
            D        <= tom_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

endmodule

// File: tb/tb_sequenciador_notas.sv
// Bench for sequenciador_notas with TICK_DIV=4, SONG_LEN=4; expected outputs come from a
// per-cycle timeline expanded from the song table (note beats then one silent beat).
module tb_sequenciador_notas;

    localparam int TD = 4;
    localparam int SL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       N1, N2, N3, D, busy, done;
    logic [3:0] idx;

    int checks = 0;
    int errors = 0;

    // {note[2:0], tone, busy, done, idx[3:0]} for each cycle after the start edge
    logic [9:0] tl[$];

    always #5 clk = ~clk;

    sequenciador_notas #(
        .TICK_DIV (TD),
        .SONG_LEN (SL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .N1    (N1),
        .N2    (N2),
        .N3    (N3),
        .D     (D),
        .busy  (busy),
        .done  (done),
        .idx   (idx)
    );

    function automatic logic [9:0] obs();
        return {N1, N2, N3, D, busy, done, idx};
    endfunction

    task automatic build_timeline();
        int notas[4] = '{3, 4, 5, 7};
        int tons[4]  = '{0, 0, 0, 1};
        int durs[4]  = '{1, 0, 0, 2};
        tl.delete();
        for (int i = 0; i < SL; i++) begin
            repeat ((durs[i] + 1) * TD) tl.push_back({3'(notas[i]), 1'(tons[i]), 1'b1, 1'b0, 4'(i)});
            repeat (TD) tl.push_back({4'b0000, 1'b1, 1'b0, 4'(i)});
        end
    endtask

    function automatic logic [9:0] exp_at(int t);
        if (t < tl.size()) return tl[t];
`ifdef SEQ_LOOP_EN
        return tl[t % tl.size()];
`else
        if (t == tl.size()) return {4'b0000, 1'b0, 1'b1, 4'd0};
        return 10'b0;
`endif
    endfunction

    task automatic test_reset();
        int run;
        #2;
        if (obs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_initial got %b exp %b", obs(), 10'b0);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        run = $urandom_range(3, 30);
        repeat (run) @(posedge clk);
        #3;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun busy got %b exp 1", busy);
        end
        checks++;
        rst_n = 1'b0;
        #1;
        if (obs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_async got %b exp %b", obs(), 10'b0);
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (obs() !== 10'b0) begin
            errors++;
            $display("FAIL reset_release got %b exp %b", obs(), 10'b0);
        end
        checks++;
    endtask

    task automatic test_song(input bit noisy_start);
        int L;
        L = tl.size();
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t <= L + 1; t++) begin
            if (obs() !== exp_at(t)) begin
                errors++;
                $display("FAIL song noisy=%0d t=%0d got %b exp %b", noisy_start, t, obs(), exp_at(t));
            end
            checks++;
            start = (noisy_start && t < L) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        if (obs() !== 10'b0) begin
            errors++;
            $display("FAIL song_after_stop got %b exp %b", obs(), 10'b0);
        end
        checks++;
    endtask

    task automatic test_stop(input int s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < s; t++) begin
            if (obs() !== exp_at(t)) begin
                errors++;
                $display("FAIL stop_pre s=%0d t=%0d got %b exp %b", s, t, obs(), exp_at(t));
            end
            checks++;
            @(posedge clk); #1;
        end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        for (int t = 0; t < 2 * TD; t++) begin
            if (obs() !== 10'b0) begin
                errors++;
                $display("FAIL stop_idle s=%0d t=%0d got %b exp %b", s, t, obs(), 10'b0);
            end
            checks++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_stop();
        start = 1'b1;
        stop = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            if (obs() !== 10'b0) begin
                errors++;
                $display("FAIL start_stop t=%0d got %b exp %b", t, obs(), 10'b0);
            end
            checks++;
        end
        start = 1'b0;
        stop = 1'b0;
        @(posedge clk); #1;
        if (obs() !== 10'b0) begin
            errors++;
            $display("FAIL start_stop_release got %b exp %b", obs(), 10'b0);
        end
        checks++;
    endtask

    initial begin
        build_timeline();
        test_reset();
        test_song(1'b0);
        test_song(1'b1);
        test_song(1'b1);
        test_stop(3);
        for (int k = 0; k < 3; k++) test_stop($urandom_range(1, tl.size() - 1));
        test_start_stop();
        test_song(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
